// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default mult/div latency, register-index width and the dependency helper.
package hazard_ctrl_pkg;

  localparam int REG_W      = 5;
  localparam int MD_LAT_DEF = 4;
  // Latency counter width; holds MD_LAT-1 for any latency in 1..15
  localparam int MD_CNT_W   = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when a source register depends on a pending destination; r0 never does
  function automatic logic reg_dep(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != {REG_W{1'b0}}) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// The master side drives the pipeline status, the slave side answers with
// write enables, flushes and mult/div scheduling status.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rt_i;
  logic             id_hilo_use_i;
  logic             id_ex_memread_i;
  logic [REG_W-1:0] id_ex_rt_i;
  logic             ex_md_start_i;
  logic             mem_branch_taken_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             ex_mem_flush_o;
  logic             md_start_o;
  logic             md_busy_o;
  logic             md_done_o;
  logic             md_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_hilo_use_i,
           id_ex_memread_i, id_ex_rt_i, ex_md_start_i, mem_branch_taken_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
           ex_mem_flush_o, md_start_o, md_busy_o, md_done_o, md_err_o,
           stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_hilo_use_i,
           id_ex_memread_i, id_ex_rt_i, ex_md_start_i, mem_branch_taken_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
           ex_mem_flush_o, md_start_o, md_busy_o, md_done_o, md_err_o,
           stall_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_md_sched.sv
// Multi-cycle HI/LO multiply/divide scheduler. Tracks whether the unit is
// busy, for how many more cycles, and flags a new start arriving while busy.
// A taken branch suppresses a new start but never cancels one in flight,
// since the mult/div is older than the branch.
module hazard_ctrl_md_sched
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_req,
  input  logic branch_taken,
  output logic md_start,
  output logic md_busy,
  output logic md_done,
  output logic md_err
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LAT - 1);

  md_state_e           state_r;
  logic [MD_CNT_W-1:0] count_r;
  logic                err_r;

  assign md_start = (state_r == MD_IDLE) && start_req && !branch_taken;
  assign md_busy  = (state_r == MD_BUSY);
  assign md_done  = (state_r == MD_BUSY) && (count_r == {MD_CNT_W{1'b0}});
  assign md_err   = err_r;

  // Idle/busy sequencing, latency countdown and sticky start-while-busy flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= MD_IDLE;
      count_r <= {MD_CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start_req && !branch_taken) begin
            count_r <= LOAD_VAL;
            state_r <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (count_r == {MD_CNT_W{1'b0}}) begin
            state_r <= MD_IDLE;
          end else begin
            count_r <= count_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
          end
          if (start_req) begin
            err_r <= 1'b1;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          count_r <= {MD_CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller. Detects load-use and HI/LO
// hazards, stalls the front end, flushes wrong-path work on a taken branch
// and counts stall cycles with a saturating counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);

  logic             md_start_s;
  logic             md_busy_s;
  logic             md_done_s;
  logic             md_err_s;
  logic             lu_s;
  logic             hl_s;
  logic             stall_s;
  logic [CNT_W-1:0] stall_cnt_r;

  hazard_ctrl_md_sched #(.MD_LAT(MD_LAT)) u_md_sched (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_req    (bus.ex_md_start_i),
    .branch_taken (bus.mem_branch_taken_i),
    .md_start     (md_start_s),
    .md_busy      (md_busy_s),
    .md_done      (md_done_s),
    .md_err       (md_err_s)
  );

  // Hazard detection; a taken branch squashes the dependent instruction anyway
  always_comb begin
    lu_s = bus.id_ex_memread_i &&
           (reg_dep(bus.id_ex_rt_i, bus.id_rs_i) ||
            (bus.id_uses_rt_i && reg_dep(bus.id_ex_rt_i, bus.id_rt_i)));
    hl_s    = bus.id_hilo_use_i && (md_busy_s || md_start_s);
    stall_s = (lu_s || hl_s) && !bus.mem_branch_taken_i;
  end

  // Pipeline control outputs: reset, then branch, then stall, then normal flow
  always_comb begin
    bus.pc_write_o     = 1'b1;
    bus.if_id_write_o  = 1'b1;
    bus.if_id_flush_o  = 1'b0;
    bus.id_ex_flush_o  = 1'b0;
    bus.ex_mem_flush_o = 1'b0;
    if (rst_i) begin
      bus.pc_write_o     = 1'b0;
      bus.if_id_write_o  = 1'b0;
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_flush_o  = 1'b1;
      bus.ex_mem_flush_o = 1'b1;
    end else if (bus.mem_branch_taken_i) begin
      bus.if_id_flush_o  = 1'b1;
      bus.id_ex_flush_o  = 1'b1;
      bus.ex_mem_flush_o = 1'b1;
    end else if (stall_s) begin
      bus.pc_write_o    = 1'b0;
      bus.if_id_write_o = 1'b0;
      bus.id_ex_flush_o = 1'b1;
    end else begin
      bus.pc_write_o    = 1'b1;
      bus.if_id_write_o = 1'b1;
    end
  end

  // Mult/div status forwarded to the pipeline, held quiet during reset
  always_comb begin
    bus.md_start_o  = md_start_s && !rst_i;
    bus.md_busy_o   = md_busy_s && !rst_i;
    bus.md_done_o   = md_done_s && !rst_i;
    bus.md_err_o    = md_err_s;
    bus.stall_cnt_o = stall_cnt_r;
  end

  // Saturating count of cycles in which the front end was stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the single-cycle
// hazard/branch equations, plus hand-written multi-cycle sequences for
// mult/div timing, branch priority, protocol error, async reset and
// counter saturation. A second instance runs with a one-cycle mult/div.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.CNT_W(4))  bus ();
  hazard_ctrl_if #(.CNT_W(16)) bus2 ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  hazard_ctrl #(.MD_LAT(1), .CNT_W(16)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.slave)
  );

  // Second instance sees exactly the same pipeline inputs
  assign bus2.id_rs_i            = bus.id_rs_i;
  assign bus2.id_rt_i            = bus.id_rt_i;
  assign bus2.id_uses_rt_i       = bus.id_uses_rt_i;
  assign bus2.id_hilo_use_i      = bus.id_hilo_use_i;
  assign bus2.id_ex_memread_i    = bus.id_ex_memread_i;
  assign bus2.id_ex_rt_i         = bus.id_ex_rt_i;
  assign bus2.ex_md_start_i      = bus.ex_md_start_i;
  assign bus2.mem_branch_taken_i = bus.mem_branch_taken_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       hilo;
    logic       mr;
    logic [4:0] exrt;
    logic       md;
    logic       br;
    logic [6:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, md_start, md_busy}
  } vec_t;

  localparam logic [6:0] PASS  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] BRNCH = 7'b1111100;

  vec_t vecs [12];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.id_rs_i            = 5'd0;
    bus.id_rt_i            = 5'd0;
    bus.id_uses_rt_i       = 1'b0;
    bus.id_hilo_use_i      = 1'b0;
    bus.id_ex_memread_i    = 1'b0;
    bus.id_ex_rt_i         = 5'd0;
    bus.ex_md_start_i      = 1'b0;
    bus.mem_branch_taken_i = 1'b0;
  endtask

  function automatic logic [6:0] ctl();
    return {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
            bus.id_ex_flush_o, bus.ex_mem_flush_o, bus.md_start_o, bus.md_busy_o};
  endfunction

  initial begin
    //           rs     rt    ur    hilo  mr    exrt   md    br    expected
    vecs[0]  = '{5'd8,  5'd0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, STALL}; // lu on Rs
    vecs[1]  = '{5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, PASS};  // r0 never hazards
    vecs[2]  = '{5'd1,  5'd9, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, PASS};  // Rt match, Rt unused
    vecs[3]  = '{5'd1,  5'd9, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, STALL}; // lu on Rt
    vecs[4]  = '{5'd8,  5'd0, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, PASS};  // not a load
    vecs[5]  = '{5'd0,  5'd0, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, PASS};  // r0 via Rt
    vecs[6]  = '{5'd8,  5'd0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, BRNCH}; // branch beats lu
    vecs[7]  = '{5'd8,  5'd0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, BRNCH}; // branch blocks md start
    vecs[8]  = '{5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, PASS};  // hilo use, unit idle
    vecs[9]  = '{5'd31, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, STALL}; // top register
    vecs[10] = '{5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, STALL}; // both sources match
    vecs[11] = '{5'd3,  5'd4, 1'b1, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, PASS};  // no match

    // Reset state, with a start request that must be suppressed
    rst = 1'b1;
    idle_in();
    bus.ex_md_start_i = 1'b1;
    #3;
    chk("reset_ctl", {25'd0, ctl()}, {25'd0, 7'b0011100});
    chk("reset_md", {29'd0, bus.md_done_o, bus.md_err_o, bus.md_start_o}, 32'd0);
    chk("reset_cnt", {28'd0, bus.stall_cnt_o}, 32'd0);
    #5;
    rst = 1'b0;
    idle_in();

    // Single-cycle equations from the vector table
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.id_rs_i            = vecs[i].rs;
      bus.id_rt_i            = vecs[i].rt;
      bus.id_uses_rt_i       = vecs[i].ur;
      bus.id_hilo_use_i      = vecs[i].hilo;
      bus.id_ex_memread_i    = vecs[i].mr;
      bus.id_ex_rt_i         = vecs[i].exrt;
      bus.ex_md_start_i      = vecs[i].md;
      bus.mem_branch_taken_i = vecs[i].br;
      #3;
      chk($sformatf("vec%0d", i), {25'd0, ctl()}, {25'd0, vecs[i].exp});
      if (vecs[i].exp[6] == 1'b0) exp_cnt++;
    end
    tick();
    idle_in();
    #3;
    chk("table_cnt", {28'd0, bus.stall_cnt_o}, exp_cnt);

    // Mult/div with a dependent mfhi held in ID
    tick();
    bus.ex_md_start_i = 1'b1;
    bus.id_hilo_use_i = 1'b1;
    #3;
    chk("md_t_start", {31'd0, bus.md_start_o}, 32'd1);
    chk("md_t_stall", {31'd0, bus.pc_write_o}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.ex_md_start_i = 1'b0;
      #3;
      chk($sformatf("md_t%0d", k), {29'd0, bus.md_busy_o, bus.md_done_o, bus.pc_write_o},
          (k <= 4) ? {29'd0, 1'b1, (k == 4), 1'b0} : 32'd1);
      if (k == 1) chk("lat1_t1", {30'd0, bus2.md_busy_o, bus2.md_done_o}, 32'd3);
      if (k == 2) chk("lat1_t2", {30'd0, bus2.md_busy_o, bus2.md_done_o}, 32'd0);
    end
    chk("md_cnt", {28'd0, bus.stall_cnt_o}, exp_cnt + 5);

    // Branch together with load-use and a mult/div start
    tick();
    idle_in();
    bus.id_rs_i            = 5'd8;
    bus.id_ex_rt_i         = 5'd8;
    bus.id_ex_memread_i    = 1'b1;
    bus.ex_md_start_i      = 1'b1;
    bus.mem_branch_taken_i = 1'b1;
    #3;
    chk("br_ctl", {25'd0, ctl()}, {25'd0, BRNCH});
    tick();
    idle_in();
    #3;
    chk("br_after", {27'd0, bus.stall_cnt_o == 4'(exp_cnt + 5), bus.md_busy_o, 3'd0}, 32'd16);

    // Start while busy, then async reset mid-operation
    tick();
    bus.ex_md_start_i = 1'b1;
    #3;
    chk("err_start", {31'd0, bus.md_start_o}, 32'd1);
    tick();
    #3;
    chk("err_before", {30'd0, bus.md_err_o, bus.md_start_o}, 32'd0);
    tick();
    bus.ex_md_start_i = 1'b0;
    #3;
    chk("err_set", {30'd0, bus.md_err_o, bus.md_busy_o}, 32'd3);
    tick();
    rst = 1'b1;
    bus.ex_md_start_i = 1'b1;
    #1;
    chk("arst_ctl", {25'd0, ctl()}, {25'd0, 7'b0011100});
    chk("arst_md", {30'd0, bus.md_done_o, bus.md_err_o}, 32'd0);
    tick();
    chk("arst_nodone", {30'd0, bus.md_done_o, bus.md_busy_o}, 32'd0);
    rst = 1'b0;
    idle_in();
    tick();
    #3;
    chk("post_rst", {27'd0, bus.stall_cnt_o, bus.md_busy_o}, 32'd0);

    // Hold a load-use stall long enough to saturate the 4-bit counter
    bus.id_rs_i         = 5'd8;
    bus.id_ex_rt_i      = 5'd8;
    bus.id_ex_memread_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat14", {28'd0, bus.stall_cnt_o}, 32'd14);
      if (i == 15) chk("sat15", {28'd0, bus.stall_cnt_o}, 32'd15);
      if (i == 20) chk("sat20", {28'd0, bus.stall_cnt_o}, 32'd15);
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
